lector_de_memoria: RTL and testbench

Read side of the memory-select interface. Each one-cycle SEL strobe from the memory selector causes one read of a synchronous single-port memory at an internal 11-bit address pointer. The block captures the read data and presents it on a valid/ready output handshake. The pointer then advances, wraps at LAST_ADDR, and a DONE pulse marks the completion of each full sweep.

---
 rtl/lector_de_memoria.sv | 157 +++++++++++++++
 tb/tb_lector_de_memoria.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lector_de_memoria.sv
// ---------------------------------------------------------------------------
// lector_de_memoria: SEL-strobed memory reader, valid/ready output, DONE per sweep; optional LECTOR_PENDING_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lector_de_memoria #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int LAST_ADDR = 2047
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CE,
  input  logic              start,
  input  logic              SEL,
  output logic [ADDR_W-1:0] ADDR,
  output logic              RD_EN,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic [DATA_W-1:0] DOUT,
  output logic              VALID,
  input  logic              READY,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(LAST_ADDR);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              w_req;

`ifdef LECTOR_PENDING_EN
  logic pend_q, pend_d;

  // A request seen while busy is replayed in the next IDLE cycle.
  assign w_req = SEL | pend_q;

  always_comb begin
    pend_d = pend_q;
    if (start) begin
      pend_d = 1'b0;
    end else if (state_q == c_IDLE) begin
      pend_d = pend_q & SEL;
    end else begin
      pend_d = pend_q | SEL;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pend_q <= 1'b0;
    end else if (CE) begin
      pend_q <= pend_d;
    end
  end
`else
  assign w_req = SEL;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= c_IDLE;
    end else if (CE) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = c_IDLE;
    end else begin
      case (state_q)
        c_IDLE:  if (w_req) state_d = c_WAIT;
        c_WAIT:  state_d = c_HOLD;
        c_HOLD:  if (READY) state_d = c_IDLE;
        default: state_d = c_IDLE;
      endcase
    end
  end

  // RD_EN and DONE default low so they only pulse for one enabled cycle.
  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    rd_en_d = 1'b0;
    dout_d  = dout_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (start) begin
      ptr_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (w_req) begin
            addr_d  = ptr_q;
            rd_en_d = 1'b1;
          end
        end
        c_WAIT: begin
          dout_d  = RD_DATA;
          valid_d = 1'b1;
        end
        c_HOLD: begin
          if (READY) begin
            valid_d = 1'b0;
            if (ptr_q == c_LAST) begin
              ptr_d  = '0;
              done_d = 1'b1;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ptr_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (CE) begin
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign ADDR  = addr_q;
  assign RD_EN = rd_en_q;
  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign DONE  = done_q;
  assign BUSY  = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_lector_de_memoria.sv
// ---------------------------------------------------------------------------
// tb_lector_de_memoria: randomized directed bench for lector_de_memoria against a pointer/memory model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lector_de_memoria;

  localparam int DW   = 8;
  localparam int AW   = 11;
  localparam int LAST = 7;

  logic          CLK;
  logic          RESET;
  logic          CE;
  logic          start;
  logic          SEL;
  logic [AW-1:0] ADDR;
  logic          RD_EN;
  logic [DW-1:0] RD_DATA;
  logic [DW-1:0] DOUT;
  logic          VALID;
  logic          READY;
  logic          BUSY;
  logic          DONE;

  logic [DW-1:0] mem [0:2047];
  int            ptr_m;
  int            vectors;
  int            miscompares;

  lector_de_memoria #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .LAST_ADDR(LAST)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .CE     (CE),
    .start  (start),
    .SEL    (SEL),
    .ADDR   (ADDR),
    .RD_EN  (RD_EN),
    .RD_DATA(RD_DATA),
    .DOUT   (DOUT),
    .VALID  (VALID),
    .READY  (READY),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  // Memory presents the addressed word while the read is enabled.
  assign RD_DATA = RD_EN ? mem[ADDR] : 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_issue();
    chk("issue_rd_en", RD_EN, 1);
    chk("issue_addr", ADDR, ptr_m);
    chk("issue_busy", BUSY, 1);
    chk("issue_done", DONE, 0);
  endtask

  // Called in the WAIT cycle; completes the read with 'stall' cycles of backpressure.
  task automatic finish_read(input int stall, input bit sel_wait);
    logic [DW-1:0] d;
    d     = mem[ptr_m];
    SEL   = sel_wait;
    READY = 1'($urandom_range(0, 1));
    tick();
    SEL   = 1'b0;
    READY = 1'b0;
    chk("valid_rise", VALID, 1);
    chk("dout", DOUT, d);
    chk("rd_en_drop", RD_EN, 0);
    repeat (stall) begin
      tick();
      chk("valid_hold", VALID, 1);
      chk("dout_hold", DOUT, d);
    end
    READY = 1'b1;
    tick();
    READY = 1'b0;
    chk("accept_valid", VALID, 0);
    chk("accept_busy", BUSY, 0);
    chk("accept_done", DONE, (ptr_m == LAST));
    ptr_m = (ptr_m == LAST) ? 0 : ptr_m + 1;
  endtask

  task automatic do_read(input int stall, input bit sel_wait);
    SEL = 1'b1;
    tick();
    expect_issue();
    finish_read(stall, sel_wait);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ptr_m       = 0;
    for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
    mem[0] = 8'hA5;
    RESET = 1'b0;
    CE    = 1'b1;
    start = 1'b0;
    SEL   = 1'b0;
    READY = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    chk("rst_addr", ADDR, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_rd_en", RD_EN, 0);
    chk("rst_dout", DOUT, 0);

    // Single read of 0xA5 at address 0, then a 5-cycle stall at address 1.
    do_read(0, 0);
    do_read(5, 0);

    // Freeze in WAIT for four cycles.
    SEL = 1'b1;
    tick();
    expect_issue();
    SEL = 1'b0;
    CE  = 1'b0;
    repeat (4) begin
      tick();
      chk("frz_valid", VALID, 0);
      chk("frz_rd_en", RD_EN, 1);
      chk("frz_busy", BUSY, 1);
      chk("frz_addr", ADDR, ptr_m);
    end
    CE = 1'b1;
    finish_read(0, 0);

    // SEL with CE low is not seen.
    CE  = 1'b0;
    SEL = 1'b1;
    tick();
    chk("ce0_rd_en", RD_EN, 0);
    chk("ce0_busy", BUSY, 0);
    CE  = 1'b1;
    SEL = 1'b0;
    tick();
    chk("ce0_after", RD_EN, 0);

    // Restart while holding the word at address 5.
    while (ptr_m != 5) do_read(int'($urandom_range(0, 2)), 0);
    SEL = 1'b1;
    tick();
    expect_issue();
    SEL = 1'b0;
    tick();
    chk("st_hold_valid", VALID, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("st_valid", VALID, 0);
    chk("st_busy", BUSY, 0);
    chk("st_rd_en", RD_EN, 0);
    ptr_m = 0;

    // start together with SEL drops the request.
    start = 1'b1;
    SEL   = 1'b1;
    tick();
    start = 1'b0;
    SEL   = 1'b0;
    chk("stsel_rd_en", RD_EN, 0);
    chk("stsel_busy", BUSY, 0);
    tick();
    chk("stsel_rd_en2", RD_EN, 0);
    do_read(0, 0);

    // Randomized traffic across two full sweeps.
    for (int n = 0; n < 20; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        SEL   = 1'b0;
        READY = 1'($urandom_range(0, 1));
        tick();
        chk("gap_busy", BUSY, 0);
        chk("gap_rd_en", RD_EN, 0);
        chk("gap_done", DONE, 0);
      end
      READY      = 1'b0;
      mem[ptr_m] = 8'($urandom);
      do_read(int'($urandom_range(0, 3)), 0);
    end

    // SEL arriving while the read is in WAIT.
    do_read(0, 1);
`ifdef LECTOR_PENDING_EN
    tick();
    expect_issue();
    finish_read(1, 0);
`else
    tick();
    chk("busy_sel_no_rd", RD_EN, 0);
    chk("busy_sel_idle", BUSY, 0);
    do_read(0, 0);
`endif

    // Reset asserted mid-HOLD with a nonzero address on the bus.
    if (ptr_m == 0) do_read(0, 0);
    SEL = 1'b1;
    tick();
    expect_issue();
    SEL = 1'b0;
    tick();
    chk("rh_valid_pre", VALID, 1);
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    chk("rh_addr", ADDR, 0);
    chk("rh_valid", VALID, 0);
    chk("rh_busy", BUSY, 0);
    chk("rh_done", DONE, 0);
    ptr_m = 0;
    do_read(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
